// File: rtl/hilo_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_md_unit
//  Purpose  : HI/LO register pair with a built-in multiply, multiply-accumulate,
//             multiply-subtract and iterative restoring-divide datapath. It sits
//             beside the EX stage and accepts one op per valid/ready handshake.
//  Ports    : cpu_clk_50M  - clock, rising edge
//             cpu_rst_n    - asynchronous reset, active HIGH despite its name
//             flush_i      - aborts the in-flight op and blocks acceptance
//             op_valid_i   - op request
//             op_ready_o   - unit is idle and can take an op
//             op_i         - 0 NOP,1 MTHI,2 MTLO,3 MULT,4 MADD,5 MSUB,6 DIV,7 NOP
//             sign_i       - signed operands when 1
//             src_a_i      - multiplicand / dividend / MTHI-MTLO data
//             src_b_i      - multiplier / divisor
//             hi_o, lo_o   - HI and LO registers
//             done_o       - one-cycle pulse after a MULT/MADD/MSUB/DIV write
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_md_unit #(
    parameter int DATA_W    = 32,
    parameter int DIV_CNT_W = 6
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              flush_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [2:0]        op_i,
    input  logic              sign_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              done_o
);

    localparam int c_w2 = 2 * DATA_W;

    localparam logic [2:0] c_op_mthi = 3'd1;
    localparam logic [2:0] c_op_mtlo = 3'd2;
    localparam logic [2:0] c_op_mult = 3'd3;
    localparam logic [2:0] c_op_madd = 3'd4;
    localparam logic [2:0] c_op_msub = 3'd5;
    localparam logic [2:0] c_op_div  = 3'd6;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_mul     = 2'd1;
    localparam logic [1:0] c_st_div_run = 2'd2;
    localparam logic [1:0] c_st_div_fix = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DATA_W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic [c_w2-1:0]      prod_q, prod_d;     // registered full-width product
    logic [c_w2-1:0]      acc_q, acc_d;       // {HI,LO} snapshot at acceptance
    logic [2:0]           mop_q, mop_d;
    logic [DATA_W-1:0]    quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]    dvs_q, dvs_d;
    logic [DATA_W-1:0]    dvd_raw_q, dvd_raw_d;
    logic                 qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    logic                 w_accept;
    logic [c_w2-1:0]      w_a_ext, w_b_ext, w_prod, w_mul_res;
    logic                 w_a_neg, w_b_neg;
    logic [DATA_W-1:0]    w_a_mag, w_b_mag, w_q_fix, w_r_fix;
    logic [DATA_W:0]      w_rem_sh, w_diff;

    assign op_ready_o = (state_q == c_st_idle);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign done_o     = done_q;

    assign w_accept = op_valid_i & op_ready_o & ~flush_i;

    // The low 2*DATA_W bits of an extended product are correct for both
    // signed and unsigned operands, so one multiplier serves both modes.
    assign w_a_ext = sign_i ? {{DATA_W{src_a_i[DATA_W-1]}}, src_a_i} : {{DATA_W{1'b0}}, src_a_i};
    assign w_b_ext = sign_i ? {{DATA_W{src_b_i[DATA_W-1]}}, src_b_i} : {{DATA_W{1'b0}}, src_b_i};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        case (mop_q)
            c_op_madd: w_mul_res = acc_q + prod_q;
            c_op_msub: w_mul_res = acc_q - prod_q;
            default:   w_mul_res = prod_q;
        endcase
    end

    // Magnitudes; the negation of MIN wraps to MIN, which is the correct
    // unsigned magnitude.
    assign w_a_neg = sign_i & src_a_i[DATA_W-1];
    assign w_b_neg = sign_i & src_b_i[DATA_W-1];
    assign w_a_mag = w_a_neg ? -src_a_i : src_a_i;
    assign w_b_mag = w_b_neg ? -src_b_i : src_b_i;

    // Restoring step: remainder < divisor always, so the shifted partial
    // remainder fits in DATA_W+1 bits and the borrow is the MSB of the difference.
    assign w_rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, dvs_q};

    assign w_q_fix = qneg_q ? -quo_q : quo_q;
    assign w_r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        prod_d    = prod_q;
        acc_d     = acc_q;
        mop_d     = mop_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        dvd_raw_d = dvd_raw_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    case (op_i)
                        c_op_mthi: hi_d = src_a_i;
                        c_op_mtlo: lo_d = src_a_i;
                        c_op_mult, c_op_madd, c_op_msub: begin
                            prod_d  = w_prod;
                            acc_d   = {hi_q, lo_q};
                            mop_d   = op_i;
                            state_d = c_st_mul;
                        end
                        c_op_div: begin
                            quo_d     = w_a_mag;
                            rem_d     = '0;
                            dvs_d     = w_b_mag;
                            dvd_raw_d = src_a_i;
                            qneg_d    = w_a_neg ^ w_b_neg;
                            rneg_d    = w_a_neg;
                            dz_d      = (src_b_i == '0);
                            cnt_d     = DIV_CNT_W'(DATA_W);
                            state_d   = c_st_div_run;
                        end
                        default: ;
                    endcase
                end
            end
            c_st_mul: begin
                state_d = c_st_idle;
                if (!flush_i) begin
                    {hi_d, lo_d} = w_mul_res;
                    done_d       = 1'b1;
                end
            end
            c_st_div_run: begin
                if (flush_i) begin
                    state_d = c_st_idle;
                end else begin
                    quo_d = {quo_q[DATA_W-2:0], ~w_diff[DATA_W]};
                    rem_d = w_diff[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
                    cnt_d = cnt_q - DIV_CNT_W'(1);
                    if (cnt_q == DIV_CNT_W'(1)) begin
                        state_d = c_st_div_fix;
                    end
                end
            end
            default: begin // c_st_div_fix
                state_d = c_st_idle;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = dvd_raw_q;
                    end else begin
                        lo_d = w_q_fix;
                        hi_d = w_r_fix;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
        if (cpu_rst_n) begin
            state_q   <= c_st_idle;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            mop_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            mop_q     <= mop_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            dvd_raw_q <= dvd_raw_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_md_unit
//  Purpose  : Self-checking bench for hilo_md_unit: directed scenarios with
//             literal expectations plus randomized ops against a behavioural
//             model that works from plain arithmetic and op latencies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_md_unit;

    localparam int W = 32;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          flush_i    = 1'b0;
    logic          op_valid_i = 1'b0;
    logic          sign_i     = 1'b0;
    logic [2:0]    op_i       = 3'd0;
    logic [W-1:0]  src_a_i    = '0;
    logic [W-1:0]  src_b_i    = '0;
    logic          op_ready_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_chk = 0;
    int n_err = 0;

    hilo_md_unit #(.DATA_W(W), .DIV_CNT_W(6)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst),
        .flush_i     (flush_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_i        (op_i),
        .sign_i      (sign_i),
        .src_a_i     (src_a_i),
        .src_b_i     (src_b_i),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [63:0] mul_model(input logic [2:0] op, input logic s,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] hilo);
        longint sa, sb;
        logic [63:0] p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = 64'(sa * sb);
        if (op == 3'd4) return hilo + p;
        if (op == 3'd5) return hilo - p;
        return p;
    endfunction

    // Returns {HI(remainder), LO(quotient)}.
    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_done = 1'b0;
    int          m_cnt  = 0;     // edges left until the pending result lands
    logic [63:0] m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                if (flush_i) begin
                    m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_hi   <= m_res[63:32];
                        m_lo   <= m_res[31:0];
                        m_done <= 1'b1;
                    end
                end
            end else if (op_valid_i && !flush_i) begin
                case (op_i)
                    3'd1: m_hi <= src_a_i;
                    3'd2: m_lo <= src_a_i;
                    3'd3, 3'd4, 3'd5: begin
                        m_res <= mul_model(op_i, sign_i, src_a_i, src_b_i, {m_hi, m_lo});
                        m_cnt <= 1;
                    end
                    3'd6: begin
                        m_res <= div_model(sign_i, src_a_i, src_b_i);
                        m_cnt <= W + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_hi", hi_o, m_hi);
            chk("cyc_lo", lo_o, m_lo);
            chk("cyc_done", done_o, m_done);
            chk("cyc_ready", op_ready_o, (m_cnt == 0));
        end
    end

    // ---------------- drivers ----------------
    task automatic do_op(input logic [2:0] op, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
        op_valid_i = 1'b1;
        op_i       = op;
        sign_i     = s;
        src_a_i    = a;
        src_b_i    = b;
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        op_i       = 3'($urandom);
        sign_i     = 1'($urandom);
        src_a_i    = $urandom;
        src_b_i    = $urandom;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (op_ready_o !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_bound", op_ready_o, 1);
    endtask

    task automatic div_wait();
        repeat (W + 1) @(posedge clk);
        #1;
    endtask

    logic [2:0]  r_op;
    logic        r_s;
    logic [31:0] r_a, r_b;
    int          r_sel;

    initial begin
        chk("model_div_neg", div_model(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_madd", mul_model(3'd4, 1'b0, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF),
            64'h0000_0001_0000_0000);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", op_ready_o, 1);
        rst = 1'b0;

        // MTHI / MTLO back to back
        do_op(3'd1, 1'b0, 32'h1234_5678, 32'd0);
        chk("mthi", hi_o, 32'h1234_5678);
        do_op(3'd2, 1'b0, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo", lo_o, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi_o, 32'h1234_5678);
        chk("mt_ready", op_ready_o, 1);

        // MULT signed -2 * 3
        do_op(3'd3, 1'b1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", op_ready_o, 0);
        @(posedge clk); #1;
        chk("mult_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mult_done", done_o, 1);
        chk("mult_ready", op_ready_o, 1);
        @(posedge clk); #1;
        chk("mult_done_clr", done_o, 0);

        // MADD / MSUB carry across the HI/LO boundary
        do_op(3'd1, 1'b0, 32'd0, 32'd0);
        do_op(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd0);
        do_op(3'd4, 1'b0, 32'd1, 32'd1);
        @(posedge clk); #1;
        chk("madd", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
        do_op(3'd5, 1'b0, 32'd2, 32'd1);
        @(posedge clk); #1;
        chk("msub", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFE);

        // DIV signed -7 / 2, written exactly 33 edges after acceptance
        do_op(3'd6, 1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (W) @(posedge clk);
        #1;
        chk("div_early_busy", op_ready_o, 0);
        chk("div_early_lo", lo_o, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk("div_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_done", done_o, 1);

        do_op(3'd6, 1'b0, 32'd100, 32'd0);
        div_wait();
        chk("div_zero", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);

        do_op(3'd6, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        div_wait();
        chk("div_min", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // Flush at iteration 10
        do_op(3'd6, 1'b1, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_ready", op_ready_o, 1);
        chk("flush_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        chk("flush_done", done_o, 0);
        @(posedge clk); #1;
        chk("flush_done2", done_o, 0);

        // Flush together with a valid op blocks acceptance
        op_valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd1; src_a_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        op_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_block_hi", hi_o, 32'd0);

        // Reset mid-divide
        do_op(3'd1, 1'b0, 32'h55, 32'd0);
        do_op(3'd2, 1'b0, 32'hAA, 32'd0);
        do_op(3'd6, 1'b0, 32'd50, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_hi", hi_o, 0);
        chk("rst_async_lo", lo_o, 0);
        chk("rst_async_ready", op_ready_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(3'd3, 1'b0, 32'd7, 32'd6);
        @(posedge clk); #1;
        chk("post_rst_mult", {hi_o, lo_o}, 64'd42);
        chk("post_rst_done", done_o, 1);

        // Randomized ops against the model
        for (int i = 0; i < 80; i++) begin
            r_op  = 3'($urandom);
            r_s   = 1'($urandom);
            r_a   = $urandom;
            r_b   = $urandom;
            r_sel = $urandom_range(0, 7);
            if (r_sel == 0) r_b = 32'd0;
            else if (r_sel == 1) r_b = 32'($urandom_range(1, 9));
            else if (r_sel == 2) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 9) == 0) begin
                op_valid_i = 1'b1; flush_i = 1'b1;
                op_i = r_op; sign_i = r_s; src_a_i = r_a; src_b_i = r_b;
                @(posedge clk); #1;
                op_valid_i = 1'b0; flush_i = 1'b0;
            end else begin
                do_op(r_op, r_s, r_a, r_b);
                if ($urandom_range(0, 5) == 0) begin
                    repeat ($urandom_range(0, 34)) @(posedge clk);
                    #1;
                    flush_i = 1'b1;
                    @(posedge clk); #1;
                    flush_i = 1'b0;
                end
                wait_idle();
            end
        end
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
